fnd_display_arbiter: RTL

FND_DISPLAY_ARBITER -- requirements
Module: fnd_display_arbiter

---
 rtl/fnd_display_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fnd_display_arbiter.sv
// Two-requester arbiter for a shared 4-digit FND display: minimum-hold ownership,
// tie rotation by last owner, and a 0..9999 clamp on the forwarded value.
module fnd_display_arbiter #(
  parameter int unsigned TICK_DIV = 100_000,
  parameter int unsigned HOLD_MS  = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [13:0] data0,
  input  logic        req1,
  input  logic [13:0] data1,
  output logic [1:0]  gnt,
  output logic [13:0] fndData,
  output logic [3:0]  fndDot,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned DIV_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int unsigned HOLD_W = (HOLD_MS < 1) ? 1 : $clog2(HOLD_MS + 1);
  localparam logic [13:0] MAX_VAL = 14'd9999;

  // State codes equal the one-hot grant, so gnt/fndDot come straight off the register.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t              state, next_state;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [HOLD_W-1:0]   hold_cnt, next_hold, hold_inc;
  logic                hold_done;
  logic                last_owner, next_last;
  logic                busy_r;
  logic [13:0]         fnd_r;
  logic                ovf_r;
  logic                own_req, oth_req;
  logic [13:0]         own_data;
  logic                load;

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign hold_done = (hold_cnt == HOLD_W'(HOLD_MS));
  assign hold_inc  = (tick && !hold_done) ? hold_cnt + 1'b1 : hold_cnt;
  assign own_req   = (state == OWN1) ? req1 : req0;
  assign oth_req   = (state == OWN1) ? req0 : req1;
  assign own_data  = (state == OWN1) ? data1 : data0;

  always_comb begin
    next_state = state;
    next_hold  = hold_cnt;
    next_last  = last_owner;
    case (state)
      IDLE: begin
        next_hold = '0;
        if (req0 && (!req1 || last_owner)) begin
          next_state = OWN0;
        end else if (req1) begin
          next_state = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!hold_done) begin
          next_hold = hold_inc;
        end else if (oth_req) begin
          next_state = (state == OWN0) ? OWN1 : OWN0;
        end else if (own_req) begin
          next_hold = hold_inc;
        end else begin
          next_state = IDLE;
          next_hold  = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_hold  = '0;
      end
    endcase
    if (next_state != state && next_state != IDLE) begin
      next_hold = '0;
      next_last = (next_state == OWN1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state      <= next_state;
      hold_cnt   <= next_hold;
      last_owner <= next_last;
      busy_r     <= (next_state != IDLE);
    end
  end

  // Data follows the owner that held the grant during the previous cycle.
  assign load = (state != IDLE) && own_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fnd_r <= '0;
      ovf_r <= 1'b0;
    end else if (load) begin
      fnd_r <= (own_data > MAX_VAL) ? MAX_VAL : own_data;
      ovf_r <= (own_data > MAX_VAL);
    end
  end

  assign gnt     = state;
  assign fndDot  = {2'b00, state};
  assign busy    = busy_r;
  assign fndData = fnd_r;
  assign ovf     = ovf_r;

endmodule
